// File: rtl/ssd_display_engine.sv
// Status-word display stage: sequential double-dabble (or hex passthrough) into a committed
// digit buffer, scanned onto a 4-digit common-anode display. Option: SSD_LEADING_ZERO_BLANK_EN.
module ssd_display_engine #(
  parameter int REFRESH_DIV = 10000,
  localparam int VALUE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  input  logic               hex_mode,
  output logic               busy,
  output logic               overflow,
  output logic [3:0]         an,
  output logic [6:0]         cathode
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  state_t state, state_nxt;

  logic [VALUE_W-1:0] work_val, pend_val, shift_reg, start_val;
  logic               work_hex, pend_hex, pending, start_now, start_hex;
  logic [19:0]        bcd;
  logic [3:0]         shift_cnt;
  logic [15:0]        digits;
  logic [3:0]         blank;
  logic [1:0]         scan_idx;
  logic [CW-1:0]      refresh_cnt;

  function automatic logic [19:0] add3(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A fresh strobe in IDLE takes priority over the pending slot.
  always_comb begin
    state_nxt = state;
    start_now = 1'b0;
    start_val = value;
    start_hex = hex_mode;
    case (state)
      IDLE: begin
        if (value_valid) begin
          start_now = 1'b1;
        end else if (pending) begin
          start_now = 1'b1;
          start_val = pend_val;
          start_hex = pend_hex;
        end
        if (start_now) state_nxt = start_hex ? COMMIT : CONV;
      end
      CONV:    if (shift_cnt == 4'd15) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic [3:0] blank_nxt;
  always_comb begin
    blank_nxt    = 4'b0000;
    blank_nxt[3] = !work_hex && (bcd[15:12] == 4'd0);
    blank_nxt[2] = blank_nxt[3] && (bcd[11:8] == 4'd0);
    blank_nxt[1] = blank_nxt[2] && (bcd[7:4] == 4'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                blank <= 4'b0000;
    else if (state == COMMIT)  blank <= blank_nxt;
  end
`else
  assign blank = 4'b0000;
`endif

  // The digit buffer is only written in COMMIT, so it never shows a partial conversion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work_val  <= '0;
      work_hex  <= 1'b0;
      pend_val  <= '0;
      pend_hex  <= 1'b0;
      pending   <= 1'b0;
      shift_reg <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
      digits    <= '0;
      overflow  <= 1'b0;
    end else begin
      if (state == IDLE && start_now) begin
        work_val  <= start_val;
        work_hex  <= start_hex;
        shift_reg <= start_val;
        bcd       <= '0;
        shift_cnt <= '0;
        pending   <= 1'b0;
      end else if (busy && value_valid) begin
        pend_val <= value;
        pend_hex <= hex_mode;
        pending  <= 1'b1;
      end
      if (state == CONV) begin
        {bcd, shift_reg} <= {add3(bcd), shift_reg} << 1;
        shift_cnt        <= shift_cnt + 4'd1;
      end
      if (state == COMMIT) begin
        if (work_hex) begin
          digits   <= work_val;
          overflow <= 1'b0;
        end else begin
          digits   <= bcd[15:0];
          overflow <= (bcd[19:16] != 4'd0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      an          <= 4'b1111;
      cathode     <= 7'b1111111;
    end else begin
      if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        scan_idx    <= scan_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      an      <= ~(4'b0001 << scan_idx);
      cathode <= blank[scan_idx] ? 7'b1111111 : seg7(digits[{scan_idx, 2'b00} +: 4]);
    end
  end

endmodule
